// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program-counter generator.
//
// Holds the architectural fetch PC and advances it under a valid/ready
// handshake with instruction memory. Trap and branch/jump redirects are
// applied with fixed priority (trap > redirect > halt > stall > accept);
// misaligned redirect targets are rejected and reported.
//
// Optional feature macro: PC_COMPRESSED_EN
//   defined   -> compressed_in port exists, increment 2 or 4, 2-byte alignment
//   undefined -> increment always 4, 4-byte alignment
//
// Ports:
//   clk                 in   clock, rising edge
//   rst                 in   asynchronous active-high reset
//   fetch_ready_in      in   instruction memory accepts pc_out this cycle
//   stall_in            in   hazard unit holds the PC
//   halt_in             in   stop fetching
//   redirect_in         in   branch/jump taken
//   redirect_target_in  in   branch/jump target (XLEN)
//   trap_in             in   exception/interrupt redirect
//   trap_vector_in      in   trap handler address (XLEN)
//   compressed_in       in   current instruction is 16-bit (PC_COMPRESSED_EN only)
//   pc_out              out  current fetch PC (XLEN)
//   pc_plus_out         out  pc_out + increment, combinational (XLEN)
//   fetch_valid_out     out  pc_out is a valid fetch request
//   misaligned_out      out  one-cycle pulse per rejected redirect target
//   badaddr_out         out  last rejected target (XLEN)
//   fetch_count_out     out  number of accepted fetches, wraps (CNT_W)
module pc_gen #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = {XLEN{1'b0}},
    parameter int                CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready_in,
    input  logic             stall_in,
    input  logic             halt_in,
    input  logic             redirect_in,
    input  logic [XLEN-1:0]  redirect_target_in,
    input  logic             trap_in,
    input  logic [XLEN-1:0]  trap_vector_in,
`ifdef PC_COMPRESSED_EN
    input  logic             compressed_in,
`endif
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus_out,
    output logic             fetch_valid_out,
    output logic             misaligned_out,
    output logic [XLEN-1:0]  badaddr_out,
    output logic [CNT_W-1:0] fetch_count_out
);

    // Low address bits that must be zero for a legal fetch target.
`ifdef PC_COMPRESSED_EN
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(1);
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);
`endif

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   badaddr_q, badaddr_d;
    logic              misaligned_q, misaligned_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-1:0]   inc;
    logic              target_misaligned;

`ifdef PC_COMPRESSED_EN
    assign inc = compressed_in ? XLEN'(2) : XLEN'(4);
`else
    assign inc = XLEN'(4);
`endif

    assign target_misaligned = (redirect_target_in & ALIGN_MASK) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            badaddr_q    <= '0;
            misaligned_q <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            badaddr_q    <= badaddr_d;
            misaligned_q <= misaligned_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        badaddr_d    = badaddr_q;
        misaligned_d = 1'b0;
        count_d      = count_q;

        unique case (state_q)
            // One idle cycle after reset before the first fetch request;
            // redirects and traps are ignored here.
            ST_BOOT: state_d = ST_RUN;

            ST_RUN, ST_HALT: begin
                if (trap_in) begin
                    // Trap vectors are trusted: low bits are simply cleared.
                    pc_d    = trap_vector_in & ~ALIGN_MASK;
                    state_d = ST_RUN;
                end else if (redirect_in) begin
                    if (target_misaligned) begin
                        // Rejected: PC and state stay put, report the target.
                        misaligned_d = 1'b1;
                        badaddr_d    = redirect_target_in;
                    end else begin
                        pc_d    = redirect_target_in;
                        state_d = ST_RUN;
                    end
                end else if (state_q == ST_RUN) begin
                    if (halt_in) begin
                        state_d = ST_HALT;
                    end else if (!stall_in && fetch_ready_in) begin
                        pc_d    = pc_q + inc;
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = ST_BOOT;
        endcase
    end

    assign pc_out          = pc_q;
    assign pc_plus_out     = pc_q + inc;
    assign fetch_valid_out = (state_q == ST_RUN);
    assign misaligned_out  = misaligned_q;
    assign badaddr_out     = badaddr_q;
    assign fetch_count_out = count_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
`ifdef PC_COMPRESSED_EN
    localparam int ALIGN = 2;
`else
    localparam int ALIGN = 4;
`endif

    logic            clk;
    logic            rst;
    logic            fetch_ready_in;
    logic            stall_in;
    logic            halt_in;
    logic            redirect_in;
    logic [31:0]     redirect_target_in;
    logic            trap_in;
    logic [31:0]     trap_vector_in;
`ifdef PC_COMPRESSED_EN
    logic            compressed_in;
`endif
    logic [31:0]     pc_out;
    logic [31:0]     pc_plus_out;
    logic            fetch_valid_out;
    logic            misaligned_out;
    logic [31:0]     badaddr_out;
    logic [CNT_W-1:0] fetch_count_out;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0000),
        .CNT_W        (CNT_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_ready_in     (fetch_ready_in),
        .stall_in           (stall_in),
        .halt_in            (halt_in),
        .redirect_in        (redirect_in),
        .redirect_target_in (redirect_target_in),
        .trap_in            (trap_in),
        .trap_vector_in     (trap_vector_in),
`ifdef PC_COMPRESSED_EN
        .compressed_in      (compressed_in),
`endif
        .pc_out             (pc_out),
        .pc_plus_out        (pc_plus_out),
        .fetch_valid_out    (fetch_valid_out),
        .misaligned_out     (misaligned_out),
        .badaddr_out        (badaddr_out),
        .fetch_count_out    (fetch_count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: where fetch is (booting / fetching / halted), the PC,
    // the accepted-fetch tally and the last rejected target.
    logic        m_booting;
    logic        m_fetching;
    logic [31:0] m_pc;
    int          m_cnt;
    logic        m_mis;
    logic [31:0] m_bad;

    function automatic logic [31:0] cur_inc();
`ifdef PC_COMPRESSED_EN
        return compressed_in ? 32'd2 : 32'd4;
`else
        return 32'd4;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_booting  <= 1'b1;
            m_fetching <= 1'b0;
            m_pc       <= 32'h0;
            m_cnt      <= 0;
            m_mis      <= 1'b0;
            m_bad      <= 32'h0;
        end else begin
            m_mis <= 1'b0;
            if (m_booting) begin
                m_booting  <= 1'b0;
                m_fetching <= 1'b1;
            end else if (trap_in) begin
                m_pc       <= trap_vector_in - (trap_vector_in % ALIGN);
                m_fetching <= 1'b1;
            end else if (redirect_in) begin
                if ((redirect_target_in % ALIGN) != 0) begin
                    m_mis <= 1'b1;
                    m_bad <= redirect_target_in;
                end else begin
                    m_pc       <= redirect_target_in;
                    m_fetching <= 1'b1;
                end
            end else if (m_fetching) begin
                if (halt_in)
                    m_fetching <= 1'b0;
                else if (!stall_in && fetch_ready_in) begin
                    m_pc  <= m_pc + cur_inc();
                    m_cnt <= (m_cnt + 1) % (1 << CNT_W);
                end
            end
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        n_checks = n_checks + 6;
        if (pc_out !== m_pc) begin
            n_fail = n_fail + 1;
            $display("FAIL model_pc: got %h want %h at %0t", pc_out, m_pc, $time);
        end
        if (pc_plus_out !== m_pc + cur_inc()) begin
            n_fail = n_fail + 1;
            $display("FAIL model_pc_plus: got %h want %h at %0t", pc_plus_out, m_pc + cur_inc(), $time);
        end
        if (fetch_valid_out !== m_fetching) begin
            n_fail = n_fail + 1;
            $display("FAIL model_valid: got %b want %b at %0t", fetch_valid_out, m_fetching, $time);
        end
        if (misaligned_out !== m_mis) begin
            n_fail = n_fail + 1;
            $display("FAIL model_mis: got %b want %b at %0t", misaligned_out, m_mis, $time);
        end
        if (badaddr_out !== m_bad) begin
            n_fail = n_fail + 1;
            $display("FAIL model_bad: got %h want %h at %0t", badaddr_out, m_bad, $time);
        end
        if (int'(fetch_count_out) != m_cnt) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cnt: got %0d want %0d at %0t", fetch_count_out, m_cnt, $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs and hand checks happen 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fetch_ready_in = 1'b1;
        stall_in = 1'b0;
        halt_in = 1'b0;
        redirect_in = 1'b0;
        redirect_target_in = 32'h0;
        trap_in = 1'b0;
        trap_vector_in = 32'h0;
`ifdef PC_COMPRESSED_EN
        compressed_in = 1'b0;
`endif
        repeat (2) cyc();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", {31'b0, fetch_valid_out}, 32'h0);
        chk("rst_mis", {31'b0, misaligned_out}, 32'h0);
        chk("rst_bad", badaddr_out, 32'h0);
        chk("rst_cnt", {28'b0, fetch_count_out}, 32'h0);

        // Release reset with ready held: one BOOT cycle, then 0, 4, 8, 0xC.
        rst = 1'b0;
        #1 chk("boot_valid", {31'b0, fetch_valid_out}, 32'h0);
        cyc(); chk("run_valid", {31'b0, fetch_valid_out}, 32'h1);
        chk("first_pc", pc_out, 32'h0);
        cyc(); chk("seq_pc4", pc_out, 32'h4);
        cyc(); chk("seq_pc8", pc_out, 32'h8);
        cyc(); chk("seq_cnt3", {28'b0, fetch_count_out}, 32'h3);

        // Redirect to 0x100 with ready high: no count.
        redirect_in = 1'b1; redirect_target_in = 32'h100;
        cyc(); redirect_in = 1'b0;
        chk("redir_pc", pc_out, 32'h100);
        chk("redir_nocnt", {28'b0, fetch_count_out}, 32'h3);
        stall_in = 1'b1;
        repeat (3) cyc();
        chk("stall_pc", pc_out, 32'h100);
        chk("stall_cnt", {28'b0, fetch_count_out}, 32'h3);
        redirect_in = 1'b1; redirect_target_in = 32'h200;
        cyc(); redirect_in = 1'b0; stall_in = 1'b0;
        chk("stall_redir_pc", pc_out, 32'h200);

`ifndef PC_COMPRESSED_EN
        fetch_ready_in = 1'b0;
        redirect_in = 1'b1; redirect_target_in = 32'h202;
        cyc(); redirect_in = 1'b0;
        chk("mis_pc", pc_out, 32'h200);
        chk("mis_pulse", {31'b0, misaligned_out}, 32'h1);
        chk("mis_bad", badaddr_out, 32'h202);
        cyc(); chk("mis_end", {31'b0, misaligned_out}, 32'h0);
        redirect_in = 1'b1; redirect_target_in = 32'h203;
        cyc(); chk("mis_b2b1", badaddr_out, 32'h203);
        redirect_target_in = 32'h201;
        cyc(); chk("mis_b2b2", {31'b0, misaligned_out}, 32'h1);
        chk("mis_b2b_bad", badaddr_out, 32'h201);
        // Trap with a simultaneous misaligned redirect: trap wins, no pulse.
        redirect_target_in = 32'h202; trap_in = 1'b1; trap_vector_in = 32'h80;
        cyc(); redirect_in = 1'b0;
        chk("trap_pc", pc_out, 32'h80);
        chk("trap_nomis", {31'b0, misaligned_out}, 32'h0);
        trap_vector_in = 32'h87;
        cyc(); trap_in = 1'b0;
        chk("trap_mask", pc_out, 32'h84);
`endif

        // PC wrap and counter wrap.
        fetch_ready_in = 1'b1;
        redirect_in = 1'b1; redirect_target_in = 32'hFFFF_FFFC;
        cyc(); redirect_in = 1'b0;
        chk("wrap_pre", pc_out, 32'hFFFF_FFFC);
        cyc(); chk("wrap_pc", pc_out, 32'h0);
        chk("wrap_cnt4", {28'b0, fetch_count_out}, 32'h4);
        repeat (11) cyc();
        chk("cnt15", {28'b0, fetch_count_out}, 32'hF);
        cyc(); chk("cnt_wrap", {28'b0, fetch_count_out}, 32'h0);
        chk("cnt_wrap_pc", pc_out, 32'h30);

        // Halt, ready toggling, then resume by redirect.
        halt_in = 1'b1;
        cyc(); halt_in = 1'b0;
        chk("halt_valid", {31'b0, fetch_valid_out}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            fetch_ready_in = ~fetch_ready_in;
            stall_in = (i == 2);
            cyc();
        end
        stall_in = 1'b0;
        chk("halt_pc", pc_out, 32'h30);
        chk("halt_cnt", {28'b0, fetch_count_out}, 32'h0);
        fetch_ready_in = 1'b1;
        redirect_in = 1'b1; redirect_target_in = 32'h40;
        cyc(); redirect_in = 1'b0;
        chk("resume_pc", pc_out, 32'h40);
        chk("resume_valid", {31'b0, fetch_valid_out}, 32'h1);
        cyc(); chk("resume_acc", pc_out, 32'h44);

        // Trap out of HALT.
        halt_in = 1'b1;
        cyc(); halt_in = 1'b0;
        trap_in = 1'b1; trap_vector_in = 32'h100;
        cyc(); trap_in = 1'b0; fetch_ready_in = 1'b0;
        chk("halt_trap_pc", pc_out, 32'h100);
        chk("halt_trap_valid", {31'b0, fetch_valid_out}, 32'h1);

        // Asynchronous reset in the middle of a cycle.
        fetch_ready_in = 1'b1;
        cyc(); cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst_pc", pc_out, 32'h0);
        chk("arst_valid", {31'b0, fetch_valid_out}, 32'h0);
        chk("arst_cnt", {28'b0, fetch_count_out}, 32'h0);
        cyc(); rst = 1'b0;
        repeat (3) cyc();
        chk("arst_rerun", pc_out, 32'h8);

`ifdef PC_COMPRESSED_EN
        redirect_in = 1'b1; redirect_target_in = 32'h10;
        cyc(); redirect_in = 1'b0; compressed_in = 1'b1;
        cyc(); compressed_in = 1'b0;
        chk("c_pc12", pc_out, 32'h12);
        cyc(); chk("c_pc16", pc_out, 32'h16);
        fetch_ready_in = 1'b0;
        redirect_in = 1'b1; redirect_target_in = 32'h22;
        cyc(); chk("c_redir22", pc_out, 32'h22);
        redirect_target_in = 32'h23;
        cyc(); redirect_in = 1'b0;
        chk("c_rej23_pc", pc_out, 32'h22);
        chk("c_rej23_mis", {31'b0, misaligned_out}, 32'h1);
`endif

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. Holds the architectural fetch PC in a register and advances it sequentially under a valid/ready handshake with instruction memory. Applies trap and branch/jump redirects with fixed priority and flags misaligned redirect targets. Supersedes the pure combinational sequential-PC adder and sits between the control/hazard logic and the instruction-memory port.

## Interface
Parameters:
- XLEN, 32, width of all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits).
- CNT_W, 32, width of the accepted-fetch counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_ready_in  in  1  instruction memory accepts the current PC this cycle.
- stall_in  in  1  hazard unit holds the PC.
- halt_in  in  1  request to stop fetching.
- redirect_in  in  1  branch/jump taken.
- redirect_target_in  in  XLEN  branch/jump target.
- trap_in  in  1  exception/interrupt redirect.
- trap_vector_in  in  XLEN  trap handler address.
- compressed_in  in  1  current instruction is 16-bit; present only with PC_COMPRESSED_EN.
- pc_out  out  XLEN  current fetch PC.
- pc_plus_out  out  XLEN  pc_out + increment, combinational.
- fetch_valid_out  out  1  pc_out is a valid fetch request.
- misaligned_out  out  1  one-cycle pulse: rejected misaligned redirect target.
- badaddr_out  out  XLEN  last rejected target.
- fetch_count_out  out  CNT_W  count of accepted fetches.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT: fetch_valid_out=0. Advances to RUN after exactly one clock following rst deassertion.
- RUN: fetch_valid_out=1. Next-PC priority, evaluated each cycle:
  - trap_in: highest priority.
  - redirect_in.
  - halt_in.
  - stall_in.
  - accept (fetch_ready_in with no stall).
  - otherwise hold.
- trap_in: pc <= trap_vector_in with low alignment bits forced to 0, no alignment check. State -> RUN. Valid in all states except BOOT.
- redirect_in with aligned target: pc <= target; state -> RUN; also valid from HALT (resumes).
- redirect_in with misaligned target: pc unchanged; misaligned_out=1 next cycle; badaddr_out <= target. State unchanged.
- Alignment: target[1:0] must be 0 (see Configuration).
- halt_in in RUN: state -> HALT; pc unchanged; fetch_valid_out=0 from next cycle.
- Accept: pc <= pc + increment (4). fetch_count_out += 1, wrapping modulo 2^CNT_W. Accept requires fetch_valid_out=1.
- Redirect, trap, and stall never increment the counter, even when fetch_ready_in=1.
- All PC arithmetic is modulo 2^XLEN. pc_out = 2^XLEN-4 plus accept wraps to 0.

## Timing
- Reset values:
  - pc_out = RESET_VECTOR
  - fetch_valid_out = 0
  - misaligned_out = 0
  - badaddr_out = 0
  - fetch_count_out = 0
  - state = BOOT
- All outputs are registered except pc_plus_out.
- Redirect/trap latency: new PC visible on pc_out the cycle after assertion. No bubble beyond that.
- misaligned_out is high for exactly one cycle per rejected redirect. Back-to-back rejects give consecutive pulses, and badaddr_out tracks the latest.
- Simultaneous trap_in and misaligned redirect_in: trap wins, no misaligned pulse.
- Simultaneous stall_in and redirect_in: redirect wins.
- rst mid-operation: immediate asynchronous return to reset values regardless of clock.

## Configuration
- PC_COMPRESSED_EN defined:
  - compressed_in port exists.
  - Increment is 2 when compressed_in=1 on accept, else 4.
  - Alignment check uses target[0] only.
  - Trap vector forces bit 0 to 0.
  - pc_plus_out reflects compressed_in.
- PC_COMPRESSED_EN undefined:
  - compressed_in absent.
  - Increment is always 4.
  - Alignment check uses target[1:0].
  - Trap vector forces bits [1:0] to 0.

## Test plan
- Reset release, fetch_ready_in=1 held -> pc_out reads RESET_VECTOR, then after one BOOT cycle 0x0, 0x4, 0x8. fetch_valid_out rises one cycle after rst falls. fetch_count_out=3 after three accepts.
- RUN at 0x100, stall_in=1 with fetch_ready_in=1 for 3 cycles -> pc_out stays 0x100 and count unchanged. Redirect_in to 0x200 during the stall -> pc_out=0x200 next cycle.
- Redirect to 0x202 (macro off) -> pc_out unchanged, one-cycle misaligned_out=1, badaddr_out=0x202. Same cycle with trap_in, vector 0x80 -> pc_out=0x80, no pulse.
- pc_out=0xFFFF_FFFC, accept -> pc_out=0x0. fetch_count_out at 0xFFFF_FFFF, accept -> 0x0.
- halt_in in RUN -> fetch_valid_out=0 next cycle, PC frozen while fetch_ready_in toggles. Redirect to 0x40 -> RUN, pc_out=0x40, valid=1.
- Macro on, PC=0x10: compressed_in=1 accept -> 0x12; compressed_in=0 accept -> 0x16. Redirect to 0x22 is accepted. Redirect to 0x23 is rejected with misaligned_out=1.
